acc_fp16_normalizer: RTL and testbench

Downstream stage of the bit-serial FP×INT MAC: on the MAC's `done` pulse it captures the accumulator's shared exponent and two's-complement fixed-point sum, and normalizes the magnitude one bit per cycle. It then rounds to nearest-even and emits an IEEE fp16 word through a valid/ready output handshake. This closes the fp16 → fixed → fp16 loop for storing partial sums or activations.

---
 rtl/acc_norm_pkg.sv | 23 ++
 rtl/fp16_round_pack.sv | 67 ++++++
 rtl/acc_fp16_normalizer.sv | 133 +++++++++++++
 tb/tb_acc_fp16_normalizer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_norm_pkg.sv
// Shared types and fp16 constants for the fixed-point to fp16 normalizer.
package acc_norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DENORM,
    S_ROUND,
    S_OUT
  } state_t;

  localparam int FP16_BIAS   = 15;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_EXP_W  = 5;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  // DENORM never needs more shifts than this to push any representable
  // value into the subnormal range; anything smaller rounds to zero anyway.
  localparam int DENORM_MAX_SHIFT = 12;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and fp16 packing.
// mag arrives normalized (MSB set) or, for subnormals, right-shifted with
// e == 1 and the hidden bit clear. Subnormal encoding is enabled by the
// NORM_SUBNORMAL_EN macro; without it tiny results flush to signed zero.
module fp16_round_pack
  import acc_norm_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 sign,
  input  logic signed [7:0]    e,
  input  logic [ACC_WIDTH-1:0] mag,
  input  logic                 sticky,
  output logic [15:0]          fp_out,
  output logic                 ovf,
  output logic                 uf
);

  localparam int EMAX = 2 * FP16_BIAS + 1;

  logic [FP16_MANT_W-1:0] mant;
  logic [FP16_MANT_W-1:0] m_r;
  logic [FP16_MANT_W+1:0] sum;
  logic                   guard;
  logic                   rest;
  logic                   inc;
  logic                   hidden;
  logic signed [7:0]      e_r;

  // Round, propagate mantissa carry into the exponent, then classify.
  always_comb begin
    mant   = mag[ACC_WIDTH-2 -: FP16_MANT_W];
    guard  = mag[ACC_WIDTH-2-FP16_MANT_W];
    rest   = (|mag[ACC_WIDTH-3-FP16_MANT_W:0]) | sticky;
    inc    = guard & (rest | mant[0]);
    sum    = {1'b0, mag[ACC_WIDTH-1], mant} + {{(FP16_MANT_W+1){1'b0}}, inc};
    // A carry out of 1.111..1 wraps the mantissa to zero and bumps e; a
    // subnormal that carries into the hidden bit keeps e == 1 (exponent 1).
    e_r    = sum[FP16_MANT_W+1] ? e + 8'sd1 : e;
    hidden = sum[FP16_MANT_W+1] | sum[FP16_MANT_W];
    m_r    = sum[FP16_MANT_W-1:0];
    fp_out = '0;
    ovf    = 1'b0;
    uf     = 1'b0;
    if (mag == '0) begin
      fp_out = '0;
    end else if (e_r >= 8'(EMAX)) begin
      fp_out = sign ? FP16_NEG_INF : FP16_POS_INF;
      ovf    = 1'b1;
    end
`ifdef NORM_SUBNORMAL_EN
    else if (!hidden || e_r <= 8'sd0) begin
      fp_out = {sign, {FP16_EXP_W{1'b0}}, m_r};
      uf     = 1'b1;
    end
`else
    else if (!hidden || e_r <= 8'sd0) begin
      fp_out = {sign, 15'h0};
      uf     = 1'b1;
    end
`endif
    else begin
      fp_out = {sign, e_r[FP16_EXP_W-1:0], m_r};
    end
  end

endmodule

// File: rtl/acc_fp16_normalizer.sv
// Captures the MAC's shared exponent and signed fixed-point sum, normalizes
// the magnitude one bit per cycle, rounds to nearest-even and presents an
// fp16 word on a valid/ready port. NORM_SUBNORMAL_EN adds the DENORM state
// and subnormal outputs.
module acc_fp16_normalizer
  import acc_norm_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           exp_in,
  input  logic [ACC_WIDTH-1:0] fixed_in,
  output logic                 in_ready,
  output logic [15:0]          fp_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  output logic                 uf
);

  // With the magnitude's MSB at the top bit, e is directly the biased exponent.
  localparam logic signed [7:0] E_OFS = 8'(ACC_WIDTH - 1 - FRAC_BITS);

  state_t                state, nxt;
  logic                  sign;
  logic [ACC_WIDTH-1:0]  mag;
  logic signed [7:0]     e;
  logic                  sticky;
`ifdef NORM_SUBNORMAL_EN
  logic [3:0]            dcnt;
`endif
  logic [15:0]           rp_fp;
  logic                  rp_ovf;
  logic                  rp_uf;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  fp16_round_pack #(.ACC_WIDTH(ACC_WIDTH)) u_round (
    .sign   (sign),
    .e      (e),
    .mag    (mag),
    .sticky (sticky),
    .fp_out (rp_fp),
    .ovf    (rp_ovf),
    .uf     (rp_uf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic. A zero capture goes straight to ROUND, where the
  // packer emits +0, so its result appears one cycle after the capture.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = (fixed_in == '0) ? S_ROUND : S_NORM;
      S_NORM: begin
        if (mag[ACC_WIDTH-1]) begin
`ifdef NORM_SUBNORMAL_EN
          nxt = (e <= 8'sd0) ? S_DENORM : S_ROUND;
`else
          nxt = S_ROUND;
`endif
        end
      end
`ifdef NORM_SUBNORMAL_EN
      S_DENORM: if (e == 8'sd0 || dcnt == 4'(DENORM_MAX_SHIFT - 1)) nxt = S_ROUND;
`endif
      S_ROUND:  nxt = S_OUT;
      S_OUT:    if (out_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Datapath: capture, shift, and register the packed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign   <= 1'b0;
      mag    <= '0;
      e      <= '0;
      sticky <= 1'b0;
`ifdef NORM_SUBNORMAL_EN
      dcnt   <= '0;
`endif
      fp_out <= '0;
      ovf    <= 1'b0;
      uf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sign   <= fixed_in[ACC_WIDTH-1];
            // -2^(W-1) negates to itself, which reads as 2^(W-1) unsigned.
            mag    <= fixed_in[ACC_WIDTH-1] ? -fixed_in : fixed_in;
            e      <= 8'(exp_in) + E_OFS;
            sticky <= 1'b0;
`ifdef NORM_SUBNORMAL_EN
            dcnt   <= '0;
`endif
          end
        end
        S_NORM: begin
          if (!mag[ACC_WIDTH-1]) begin
            mag <= mag << 1;
            e   <= e - 8'sd1;
          end
        end
`ifdef NORM_SUBNORMAL_EN
        S_DENORM: begin
          mag    <= mag >> 1;
          sticky <= sticky | mag[0];
          e      <= e + 8'sd1;
          dcnt   <= dcnt + 4'd1;
        end
`endif
        S_ROUND: begin
          fp_out <= rp_fp;
          ovf    <= rp_ovf;
          uf     <= rp_uf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_fp16_normalizer.sv
// Scoreboard bench: stimulus pushes reference results, a negedge monitor
// pops and compares on each accepted output and checks output latency.
module tb_acc_fp16_normalizer;

  localparam int W = 32;
`ifdef NORM_SUBNORMAL_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    exp_in = '0;
  logic [W-1:0]  fixed_in = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic [15:0]   fp_out;
  logic          out_valid;
  logic          ovf;
  logic          uf;

  acc_fp16_normalizer #(.ACC_WIDTH(W), .FRAC_BITS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .exp_in    (exp_in),
    .fixed_in  (fixed_in),
    .in_ready  (in_ready),
    .fp_out    (fp_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .uf        (uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fp;
    logic        ovf;
    logic        uf;
    int          lat;
    int          k;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Round m * 2^-sh to the nearest integer, ties to even.
  function automatic longint rne(input longint m, input int sh);
    longint q, r, half;
    if (sh <= 0) return m << (-sh);
    q    = m >> sh;
    r    = m - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    return q;
  endfunction

  // Reference: value = x * 2^(ex - 25); encode as fp16 from that value.
  function automatic exp_t model(input logic [31:0] x, input logic [4:0] ex, input int k);
    exp_t   r;
    longint mag, m;
    int     p, be, s, d;
    logic   sg;
    r.k = k; r.fp = '0; r.ovf = 1'b0; r.uf = 1'b0; r.lat = 1;
    sg  = x[31];
    mag = sg ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    if (mag == 0) return r;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    be = p + int'(ex) - 10;
    s  = 31 - p;
    d  = 0;
    if (SUB && be <= 0) begin
      m    = rne(mag, 1 - int'(ex));       // units of 2^-24
      d    = (1 - be > 12) ? 12 : 1 - be;
      r.fp = {sg, m[14:0]};
      r.uf = (m < 1024);
    end else begin
      m = rne(mag, p - 10);                // 11-bit significand
      if (m == 2048) begin m = 1024; be++; end
      if (be >= 31) begin
        r.fp = sg ? 16'hFC00 : 16'h7C00; r.ovf = 1'b1;
      end else if (be <= 0) begin
        r.fp = {sg, 15'h0}; r.uf = 1'b1;
      end else begin
        r.fp = {sg, 5'(be), m[9:0]};
      end
    end
    r.lat = s + d + 2;
    return r;
  endfunction

  // Monitor: latency on each rising out_valid, data on each acceptance.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got fp_out %0h expected no output", fp_out);
        end else begin
          chk("latency", cyc - sbq[0].k, sbq[0].lat);
        end
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        chk("fp_out", fp_out, sbq[0].fp);
        chk("ovf", ovf, sbq[0].ovf);
        chk("uf", uf, sbq[0].uf);
        void'(sbq.pop_front());
      end
      prev_v = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [31:0] x, input logic [4:0] ex, input bit push);
    int n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    start = 1'b1; fixed_in = x; exp_in = ex;
    tick();
    start = 1'b0;
    if (push) sbq.push_back(model(x, ex, cyc));
  endtask

  task automatic drain();
    int n = 0;
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() > 0 && n < 3000) begin tick(); n++; end
    if (sbq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] x;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fp_out", fp_out, 16'h0000);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_uf", uf, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Directed points: unity, negative, ties, overflow, zero, tiny, most negative.
    issue(32'd1024,       5'd15, 1'b1);
    issue(32'hFFFF_F400,  5'd15, 1'b1);
    issue(32'd2049,       5'd14, 1'b1);
    issue(32'd2051,       5'd14, 1'b1);
    issue(32'h7FFF_FFFF,  5'd31, 1'b1);
    issue(32'd0,          5'd31, 1'b1);
    issue(32'd2,          5'd0,  1'b1);
    issue(32'h8000_0000,  5'd0,  1'b1);
    issue(32'hFFFF_FFFF,  5'd0,  1'b1);
    drain();

    // Random magnitudes across the full range with random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      issue(x, 5'($urandom_range(0, 31)), 1'b1);
    end
    drain();

    // Hold the result under backpressure while start pulses are ignored.
    rdy_rand  = 1'b0;
    out_ready = 1'b0;
    issue(32'd1024, 5'd15, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("hold_reached_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; fixed_in = $urandom; exp_in = 5'($urandom_range(0, 31));
      tick();
      chk("hold_fp_out", fp_out, 16'h3C00);
      chk("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;             // accept on the same edge as a start
    tick();
    start = 1'b0;
    chk("accept_in_ready", in_ready, 1'b1);
    repeat (3) tick();
    chk("dropped_start_valid", out_valid, 0);
    chk("dropped_start_in_ready", in_ready, 1'b1);
    drain();

    // Reset in the middle of NORM discards the operation at once.
    issue(32'd1, 5'd0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_fp_out", fp_out, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    issue(32'd1024, 5'd15, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
